vx_mem_tag_arb: RTL and testbench
=================================

Name: vx_mem_tag_arb

Overview:
- Parametrised N-to-1 memory request arbiter with tag-based response routing, merging several L1 cache memory ports onto one downstream L2/memory port.
- Extends each request tag with source-index LSBs and strips them from responses, so the outgoing tag width is TAG_IN_WIDTH + clog2(NUM_INPUTS).
- Replaces the fixed, compile-time widening of memory tags with a configurable block.
- New over the plain tag-width scheme: selectable round-robin/fixed-priority arbitration, per-input outstanding-read limits, a registered request path, a registered response path, and detection of invalid response indices.

Parameters:
- NUM_INPUTS, 3, number of requestor ports (≥1).
- ADDR_WIDTH, 26, line-address width.
- DATA_WIDTH, 512, line data width in bits (line size × 8).
- TAG_IN_WIDTH, 8, tag width on each input port.
- ARBITER, "R", "R" = round-robin, "F" = fixed priority (index 0 highest).
- MAX_PENDING, 16, maximum outstanding reads per input (≥1).
- Derived: LG_N = (NUM_INPUTS>1) ? clog2(NUM_INPUTS) : 0; TAG_OUT_WIDTH = TAG_IN_WIDTH + LG_N.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid_in  in  N  per-input request valid.
- req_rw_in  in  N  1 = write, 0 = read.
- req_addr_in  in  N*ADDR_WIDTH  request address, flattened with input 0 at the LSBs.
- req_byteen_in  in  N*DATA_WIDTH/8  byte enables.
- req_data_in  in  N*DATA_WIDTH  write data.
- req_tag_in  in  N*TAG_IN_WIDTH  request tag.
- req_ready_out  out  N  per-input accept.
- mem_req_valid  out  1  downstream request valid.
- mem_req_rw  out  1  downstream request rw.
- mem_req_addr  out  ADDR_WIDTH  downstream request address.
- mem_req_byteen  out  DATA_WIDTH/8  downstream byte enables.
- mem_req_data  out  DATA_WIDTH  downstream write data.
- mem_req_tag  out  TAG_OUT_WIDTH  downstream tag = {tag_in, idx}.
- mem_req_ready  in  1  downstream accept.
- mem_rsp_valid  in  1  downstream response valid.
- mem_rsp_data  in  DATA_WIDTH  response data.
- mem_rsp_tag  in  TAG_OUT_WIDTH  response tag.
- mem_rsp_ready  out  1  response accept.
- rsp_valid_out  out  N  per-input response valid.
- rsp_data_out  out  DATA_WIDTH  response data, shared by all inputs.
- rsp_tag_out  out  TAG_IN_WIDTH  response tag with index bits stripped, shared.
- rsp_ready_in  in  N  per-input response accept.
- rsp_err  out  1  sticky flag: a response arrived with an invalid index.
- busy  out  1  any pending count ≠ 0, or any output register valid.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - mem_req_valid = 0, rsp_valid_out = 0, rsp_err = 0.
  - All pending counters = 0; round-robin pointer = 0.
  - req_ready_out and mem_rsp_ready track the now-empty registers, so they reflect the empty state immediately.
  - Any in-flight contents are discarded.
- Eligibility: input i is eligible when req_valid_in[i] && !(req_rw_in[i]==0 && pend[i]==MAX_PENDING). Writes are never throttled.
- Arbitration:
  - "F": the lowest eligible index wins.
  - "R": the first eligible index at or after pointer p wins, wrapping modulo N.
  - p ← winner+1 (mod N), updated only on an accepted grant.
  - Exactly one req_ready_out bit is high: the winner's, and only when the request register can load.
- Request register: a one-entry elastic stage.
  - Loads when it is empty or mem_req_ready=1 (full throughput, 1-cycle latency).
  - Holds all fields stable while mem_req_valid && !mem_req_ready.
  - mem_req_tag = {tag_in, winner index in LG_N LSBs}.
- Pending counters, width clog2(MAX_PENDING+1):
  - Increment on an accepted read from input i.
  - Decrement on a response handshake (rsp_valid_out[i] && rsp_ready_in[i]).
  - Simultaneous increment and decrement leaves the count unchanged.
  - Never wraps: inputs are masked at the limit; a decrement at 0 is not possible for legal traffic and is asserted against in simulation.
- Response path:
  - idx = mem_rsp_tag[LG_N-1:0]; with N=1, idx is 0 and the response is passed through.
  - Response register is one entry; mem_rsp_ready = register empty or the held target's rsp_ready_in is high.
  - rsp_valid_out is one-hot at the held idx.
  - rsp_tag_out = mem_rsp_tag[TAG_OUT_WIDTH-1:LG_N]; latency 1 cycle.
- Invalid response (idx ≥ N, non-power-of-2 N only):
  - Accepted (mem_rsp_ready=1 if the register can load), then dropped without loading.
  - rsp_err is set and stays set until reset.
- Request and response paths are independent: a request accept and a response delivery may complete in the same cycle.

Test Plan:
- N=3, RR, all three inputs valid continuously, mem_req_ready=1 → grants 0,1,2,0,1,2…; mem_req_tag LSBs match; first mem_req_valid appears 1 cycle after reset release and valid.
- ARBITER="F", inputs 0 and 2 valid → input 0 is granted every cycle; input 2 is granted only after input 0 drops valid.
- MAX_PENDING=2, input 1 issues reads tag 0x5,0x6, no responses → the third read is held with req_ready_out[1]=0. Input 1 writes are still accepted. A response with tag {0x5,2'd1} → rsp_valid_out=3'b010, rsp_tag_out=0x5, and the third read is then granted.
- mem_req_ready=0 for 4 cycles with the register full → mem_req_* fields stay stable, req_ready_out=0; on release, one beat per cycle resumes.
- Response tag idx=3 with N=3 → mem_rsp_ready=1, no rsp_valid_out, rsp_err=1 until reset_n is pulled low, then rsp_err=0.
- reset_n asserted mid-transfer, with the register full and pend=1 → outputs clear immediately; after release, busy=0 and the round-robin order restarts at input 0.

Source files
------------

// File: rtl/vx_mem_tag_arb_if.sv
// Bus bundle for vx_mem_tag_arb: N requestor ports on one side, one memory port on the other.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface vx_mem_tag_arb_if #(
  parameter int NUM_INPUTS   = 3,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_IN_WIDTH = 8
);
  localparam int LG_N          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LG_N;
  localparam int BE_WIDTH      = DATA_WIDTH / 8;

  logic [NUM_INPUTS-1:0]              req_valid_in;
  logic [NUM_INPUTS-1:0]              req_rw_in;
  logic [NUM_INPUTS*ADDR_WIDTH-1:0]   req_addr_in;
  logic [NUM_INPUTS*BE_WIDTH-1:0]     req_byteen_in;
  logic [NUM_INPUTS*DATA_WIDTH-1:0]   req_data_in;
  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] req_tag_in;
  logic [NUM_INPUTS-1:0]              req_ready_out;

  logic                               mem_req_valid;
  logic                               mem_req_rw;
  logic [ADDR_WIDTH-1:0]              mem_req_addr;
  logic [BE_WIDTH-1:0]                mem_req_byteen;
  logic [DATA_WIDTH-1:0]              mem_req_data;
  logic [TAG_OUT_WIDTH-1:0]           mem_req_tag;
  logic                               mem_req_ready;

  logic                               mem_rsp_valid;
  logic [DATA_WIDTH-1:0]              mem_rsp_data;
  logic [TAG_OUT_WIDTH-1:0]           mem_rsp_tag;
  logic                               mem_rsp_ready;

  logic [NUM_INPUTS-1:0]              rsp_valid_out;
  logic [DATA_WIDTH-1:0]              rsp_data_out;
  logic [TAG_IN_WIDTH-1:0]            rsp_tag_out;
  logic [NUM_INPUTS-1:0]              rsp_ready_in;

  logic                               rsp_err;
  logic                               busy;

  modport slave (
    input  req_valid_in, req_rw_in, req_addr_in, req_byteen_in, req_data_in, req_tag_in,
    output req_ready_out,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready,
    output rsp_valid_out, rsp_data_out, rsp_tag_out,
    input  rsp_ready_in,
    output rsp_err, busy
  );

  modport master (
    output req_valid_in, req_rw_in, req_addr_in, req_byteen_in, req_data_in, req_tag_in,
    input  req_ready_out,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready,
    input  rsp_valid_out, rsp_data_out, rsp_tag_out,
    output rsp_ready_in,
    input  rsp_err, busy
  );
endinterface

// File: rtl/vx_mem_tag_arb.sv
// N-to-1 memory request arbiter: appends the source index to outgoing tags and routes
// responses back by stripping it, with per-input read throttling and registered paths.
module vx_mem_tag_arb #(
  parameter int NUM_INPUTS   = 3,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_IN_WIDTH = 8,
  parameter     ARBITER      = "R",
  parameter int MAX_PENDING  = 16
) (
  input logic             clk,
  input logic             reset_n,
  vx_mem_tag_arb_if.slave bus
);
  localparam int LG_N          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LG_N;
  localparam int IDX_W         = (LG_N > 0) ? LG_N : 1;
  localparam int BE_WIDTH      = DATA_WIDTH / 8;
  localparam int PW            = $clog2(MAX_PENDING + 1);

  logic [NUM_INPUTS-1:0]   elig;
  logic [NUM_INPUTS-1:0]   pend_inc;
  logic [NUM_INPUTS-1:0]   pend_dec;
  logic [NUM_INPUTS-1:0]   pend_nz;
  logic [NUM_INPUTS-1:0]   rsp_sel;
  logic [NUM_INPUTS-1:0]   req_ready;

  logic                    win_found;
  int                      win_i;
  int                      cand;
  logic                    can_load;
  logic                    req_accept;

  logic                    req_valid_q, req_valid_d;
  logic                    req_rw_q, req_rw_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [BE_WIDTH-1:0]     req_byteen_q, req_byteen_d;
  logic [DATA_WIDTH-1:0]   req_data_q, req_data_d;
  logic [TAG_IN_WIDTH-1:0] req_tag_q, req_tag_d;
  logic [IDX_W-1:0]        req_idx_q, req_idx_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;

  int                      rsp_in_idx;
  logic [TAG_IN_WIDTH-1:0] rsp_in_tag;
  logic                    rsp_idx_ok;
  logic                    rsp_tgt_ready;
  logic                    rsp_hs;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]        rsp_idx_q, rsp_idx_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [TAG_IN_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
  logic                    rsp_err_q, rsp_err_d;

  // Per-input outstanding-read counters; the limit masks reads only, never writes.
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
    logic [PW-1:0] cnt_q, cnt_d;

    assign elig[gi]     = bus.req_valid_in[gi] &&
                          !(!bus.req_rw_in[gi] && (cnt_q == PW'(MAX_PENDING)));
    assign pend_inc[gi] = req_accept && (win_i == gi) && !bus.req_rw_in[gi];
    assign rsp_sel[gi]  = rsp_valid_q && (rsp_idx_q == IDX_W'(gi));
    assign pend_dec[gi] = rsp_sel[gi] && bus.rsp_ready_in[gi];
    assign pend_nz[gi]  = (cnt_q != '0);

    always_comb begin
      cnt_d = cnt_q;
      case ({pend_inc[gi], pend_dec[gi]})
        2'b10:   cnt_d = cnt_q + PW'(1);
        2'b01:   cnt_d = cnt_q - PW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(pend_dec[gi] && (cnt_q == '0)));
  end

  // Fixed priority scans from 0; round-robin scans from the pointer and wraps.
  always_comb begin
    win_found = 1'b0;
    win_i     = 0;
    cand      = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = (ARBITER == "F") ? k : ((int'(ptr_q) + k) % NUM_INPUTS);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_i     = cand;
      end
    end
  end

  always_comb begin
    req_valid_d  = req_valid_q;
    req_rw_d     = req_rw_q;
    req_addr_d   = req_addr_q;
    req_byteen_d = req_byteen_q;
    req_data_d   = req_data_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    ptr_d        = ptr_q;
    req_ready    = '0;
    can_load     = !req_valid_q || bus.mem_req_ready;
    req_accept   = can_load && win_found;
    if (can_load) req_valid_d = win_found;
    if (req_accept) begin
      req_ready[win_i] = 1'b1;
      req_rw_d     = bus.req_rw_in[win_i];
      req_addr_d   = bus.req_addr_in[win_i*ADDR_WIDTH +: ADDR_WIDTH];
      req_byteen_d = bus.req_byteen_in[win_i*BE_WIDTH +: BE_WIDTH];
      req_data_d   = bus.req_data_in[win_i*DATA_WIDTH +: DATA_WIDTH];
      req_tag_d    = bus.req_tag_in[win_i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
      req_idx_d    = IDX_W'(win_i);
      ptr_d        = (win_i == NUM_INPUTS - 1) ? '0 : IDX_W'(win_i + 1);
    end
  end

  if (LG_N > 0) begin : g_idx
    assign rsp_in_idx      = int'(bus.mem_rsp_tag[LG_N-1:0]);
    assign rsp_in_tag      = bus.mem_rsp_tag[TAG_OUT_WIDTH-1:LG_N];
    assign bus.mem_req_tag = {req_tag_q, req_idx_q};
  end else begin : g_no_idx
    assign rsp_in_idx      = 0;
    assign rsp_in_tag      = bus.mem_rsp_tag;
    assign bus.mem_req_tag = req_tag_q;
  end

  assign rsp_idx_ok        = (rsp_in_idx < NUM_INPUTS);
  assign rsp_tgt_ready     = |(rsp_sel & bus.rsp_ready_in);
  assign bus.mem_rsp_ready = !rsp_valid_q || rsp_tgt_ready;
  assign rsp_hs            = bus.mem_rsp_valid && bus.mem_rsp_ready;

  // Out-of-range indices are consumed so the memory side never stalls on them.
  always_comb begin
    rsp_valid_d = rsp_valid_q && !rsp_tgt_ready;
    rsp_idx_d   = rsp_idx_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q || (rsp_hs && !rsp_idx_ok);
    if (rsp_hs && rsp_idx_ok) begin
      rsp_valid_d = 1'b1;
      rsp_idx_d   = IDX_W'(rsp_in_idx);
      rsp_data_d  = bus.mem_rsp_data;
      rsp_tag_d   = rsp_in_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_valid_q  <= 1'b0;
      req_rw_q     <= 1'b0;
      req_addr_q   <= '0;
      req_byteen_q <= '0;
      req_data_q   <= '0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      ptr_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_idx_q    <= '0;
      rsp_data_q   <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      req_valid_q  <= req_valid_d;
      req_rw_q     <= req_rw_d;
      req_addr_q   <= req_addr_d;
      req_byteen_q <= req_byteen_d;
      req_data_q   <= req_data_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_idx_q    <= rsp_idx_d;
      rsp_data_q   <= rsp_data_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready_out  = req_ready;
  assign bus.mem_req_valid  = req_valid_q;
  assign bus.mem_req_rw     = req_rw_q;
  assign bus.mem_req_addr   = req_addr_q;
  assign bus.mem_req_byteen = req_byteen_q;
  assign bus.mem_req_data   = req_data_q;
  assign bus.rsp_valid_out  = rsp_sel;
  assign bus.rsp_data_out   = rsp_data_q;
  assign bus.rsp_tag_out    = rsp_tag_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.busy           = (|pend_nz) || req_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_vx_mem_tag_arb.sv
// Directed bench for vx_mem_tag_arb: a round-robin instance with a read limit of 2 and a
// fixed-priority instance, checked against hand-computed vectors.
module tb_vx_mem_tag_arb;
  localparam int N  = 3;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vx_mem_tag_arb_if #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) bus_r ();
  vx_mem_tag_arb_if #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) bus_f ();

  vx_mem_tag_arb #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW),
                   .ARBITER("R"), .MAX_PENDING(2))
    dut_r (.clk(clk), .reset_n(reset_n), .bus(bus_r));

  vx_mem_tag_arb #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW),
                   .ARBITER("F"), .MAX_PENDING(16))
    dut_f (.clk(clk), .reset_n(reset_n), .bus(bus_f));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] valid;
    logic       mrr;
    logic [2:0] exp_ready;
    logic       exp_mv;
    logic [9:0] exp_tag;
    logic       exp_busy;
  } vec_t;

  vec_t vt [14];
  logic [9:0] etag;

  initial begin
    // Round-robin over three writers, a 4-cycle downstream stall, then drain.
    vt[0]  = '{3'b111, 1'b1, 3'b001, 1'b0, 10'h000, 1'b0};
    vt[1]  = '{3'b111, 1'b1, 3'b010, 1'b1, 10'h040, 1'b1};
    vt[2]  = '{3'b111, 1'b1, 3'b100, 1'b1, 10'h045, 1'b1};
    vt[3]  = '{3'b111, 1'b1, 3'b001, 1'b1, 10'h04A, 1'b1};
    vt[4]  = '{3'b111, 1'b1, 3'b010, 1'b1, 10'h040, 1'b1};
    vt[5]  = '{3'b111, 1'b0, 3'b000, 1'b1, 10'h045, 1'b1};
    vt[6]  = '{3'b111, 1'b0, 3'b000, 1'b1, 10'h045, 1'b1};
    vt[7]  = '{3'b111, 1'b0, 3'b000, 1'b1, 10'h045, 1'b1};
    vt[8]  = '{3'b111, 1'b0, 3'b000, 1'b1, 10'h045, 1'b1};
    vt[9]  = '{3'b111, 1'b1, 3'b100, 1'b1, 10'h045, 1'b1};
    vt[10] = '{3'b111, 1'b1, 3'b001, 1'b1, 10'h04A, 1'b1};
    vt[11] = '{3'b111, 1'b1, 3'b010, 1'b1, 10'h040, 1'b1};
    vt[12] = '{3'b000, 1'b1, 3'b000, 1'b1, 10'h045, 1'b1};
    vt[13] = '{3'b000, 1'b1, 3'b000, 1'b0, 10'h000, 1'b0};

    bus_r.req_valid_in  = '0;
    bus_r.req_rw_in     = 3'b111;
    bus_r.req_addr_in   = {26'h102, 26'h101, 26'h100};
    bus_r.req_byteen_in = '1;
    bus_r.req_data_in   = {32'hA2, 32'hA1, 32'hA0};
    bus_r.req_tag_in    = {8'h12, 8'h11, 8'h10};
    bus_r.mem_req_ready = 1'b1;
    bus_r.mem_rsp_valid = 1'b0;
    bus_r.mem_rsp_data  = '0;
    bus_r.mem_rsp_tag   = '0;
    bus_r.rsp_ready_in  = 3'b111;
    bus_f.req_valid_in  = '0;
    bus_f.req_rw_in     = '0;
    bus_f.req_addr_in   = {26'h202, 26'h201, 26'h200};
    bus_f.req_byteen_in = '1;
    bus_f.req_data_in   = '0;
    bus_f.req_tag_in    = {8'h12, 8'h11, 8'h10};
    bus_f.mem_req_ready = 1'b1;
    bus_f.mem_rsp_valid = 1'b0;
    bus_f.mem_rsp_data  = '0;
    bus_f.mem_rsp_tag   = '0;
    bus_f.rsp_ready_in  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req_valid", 64'(bus_r.mem_req_valid), 64'd0);
    chk("rst_rsp_valid", 64'(bus_r.rsp_valid_out), 64'd0);
    chk("rst_rsp_err", 64'(bus_r.rsp_err), 64'd0);
    chk("rst_busy", 64'(bus_r.busy), 64'd0);
    chk("rst_mem_rsp_ready", 64'(bus_r.mem_rsp_ready), 64'd1);
    chk("rst_req_ready", 64'(bus_r.req_ready_out), 64'd0);
    chk("rst_f_mem_req_valid", 64'(bus_f.mem_req_valid), 64'd0);

    @(negedge clk);
    reset_n = 1'b1;
    for (int v = 0; v < 14; v++) begin
      bus_r.req_valid_in  = vt[v].valid;
      bus_r.mem_req_ready = vt[v].mrr;
      #1;
      chk($sformatf("vec%0d_ready", v), 64'(bus_r.req_ready_out), 64'(vt[v].exp_ready));
      chk($sformatf("vec%0d_mreq_valid", v), 64'(bus_r.mem_req_valid), 64'(vt[v].exp_mv));
      chk($sformatf("vec%0d_busy", v), 64'(bus_r.busy), 64'(vt[v].exp_busy));
      if (vt[v].exp_mv) begin
        etag = vt[v].exp_tag;
        chk($sformatf("vec%0d_tag", v), 64'(bus_r.mem_req_tag), 64'(etag));
        chk($sformatf("vec%0d_addr", v), 64'(bus_r.mem_req_addr), 64'h100 + 64'(etag[1:0]));
        chk($sformatf("vec%0d_data", v), 64'(bus_r.mem_req_data), 64'hA0 + 64'(etag[1:0]));
        chk($sformatf("vec%0d_rw", v), 64'(bus_r.mem_req_rw), 64'd1);
      end
      $display("vec %0d: ready=%b mem_req_valid=%b tag=%h busy=%b", v,
               bus_r.req_ready_out, bus_r.mem_req_valid, bus_r.mem_req_tag, bus_r.busy);
      @(negedge clk);
    end

    // Read limit of 2 on input 1, writes still pass, response frees a slot
    bus_r.req_rw_in    = 3'b000;
    bus_r.req_valid_in = 3'b010;
    bus_r.req_tag_in   = {8'h12, 8'h05, 8'h10};
    #1 chk("pend_rd0_ready", 64'(bus_r.req_ready_out), 64'b010);
    @(negedge clk);
    bus_r.req_tag_in = {8'h12, 8'h06, 8'h10};
    #1 chk("pend_rd1_ready", 64'(bus_r.req_ready_out), 64'b010);
    chk("pend_rd0_tag", 64'(bus_r.mem_req_tag), 64'h015);
    @(negedge clk);
    bus_r.req_tag_in = {8'h12, 8'h07, 8'h10};
    #1 chk("pend_limit_ready", 64'(bus_r.req_ready_out), 64'b000);
    chk("pend_rd1_tag", 64'(bus_r.mem_req_tag), 64'h019);
    chk("pend_busy", 64'(bus_r.busy), 64'd1);
    $display("read limit: third read held, ready=%b", bus_r.req_ready_out);
    @(negedge clk);
    #1 chk("pend_limit_ready2", 64'(bus_r.req_ready_out), 64'b000);
    chk("pend_reg_empty", 64'(bus_r.mem_req_valid), 64'd0);
    bus_r.req_rw_in = 3'b010;
    #1 chk("pend_wr_ready", 64'(bus_r.req_ready_out), 64'b010);
    @(negedge clk);
    bus_r.req_rw_in = 3'b000;
    #1 chk("pend_after_wr_ready", 64'(bus_r.req_ready_out), 64'b000);
    chk("pend_wr_valid", 64'(bus_r.mem_req_valid), 64'd1);
    chk("pend_wr_tag", 64'(bus_r.mem_req_tag), 64'h01D);
    chk("pend_wr_rw", 64'(bus_r.mem_req_rw), 64'd1);
    $display("write under limit: tag=%h rw=%b", bus_r.mem_req_tag, bus_r.mem_req_rw);
    bus_r.mem_rsp_valid = 1'b1;
    bus_r.mem_rsp_tag   = 10'h015;
    bus_r.mem_rsp_data  = 32'hDEADBEEF;
    #1 chk("rsp0_mem_rsp_ready", 64'(bus_r.mem_rsp_ready), 64'd1);
    @(negedge clk);
    bus_r.mem_rsp_valid = 1'b0;
    #1 chk("rsp0_valid", 64'(bus_r.rsp_valid_out), 64'b010);
    chk("rsp0_tag", 64'(bus_r.rsp_tag_out), 64'h05);
    chk("rsp0_data", 64'(bus_r.rsp_data_out), 64'hDEADBEEF);
    chk("rsp0_still_limited", 64'(bus_r.req_ready_out), 64'b000);
    $display("response: valid=%b tag=%h data=%h", bus_r.rsp_valid_out, bus_r.rsp_tag_out, bus_r.rsp_data_out);
    @(negedge clk);
    #1 chk("rsp0_cleared", 64'(bus_r.rsp_valid_out), 64'b000);
    chk("pend_freed_ready", 64'(bus_r.req_ready_out), 64'b010);
    @(negedge clk);
    bus_r.req_valid_in = 3'b000;
    #1 chk("rd2_tag", 64'(bus_r.mem_req_tag), 64'h01D);
    chk("rd2_rw", 64'(bus_r.mem_req_rw), 64'd0);

    // Response backpressure from the target input
    bus_r.rsp_ready_in  = 3'b101;
    bus_r.mem_rsp_valid = 1'b1;
    bus_r.mem_rsp_tag   = 10'h019;
    #1 chk("bp_load_ready", 64'(bus_r.mem_rsp_ready), 64'd1);
    @(negedge clk);
    bus_r.mem_rsp_tag = 10'h01D;
    #1 chk("bp_valid", 64'(bus_r.rsp_valid_out), 64'b010);
    chk("bp_tag", 64'(bus_r.rsp_tag_out), 64'h06);
    chk("bp_mem_rsp_ready", 64'(bus_r.mem_rsp_ready), 64'd0);
    @(negedge clk);
    #1 chk("bp_hold_tag", 64'(bus_r.rsp_tag_out), 64'h06);
    chk("bp_hold_ready", 64'(bus_r.mem_rsp_ready), 64'd0);
    bus_r.rsp_ready_in = 3'b111;
    #1 chk("bp_release_ready", 64'(bus_r.mem_rsp_ready), 64'd1);
    $display("response backpressure released");
    @(negedge clk);
    bus_r.mem_rsp_valid = 1'b0;
    #1 chk("bp_next_valid", 64'(bus_r.rsp_valid_out), 64'b010);
    chk("bp_next_tag", 64'(bus_r.rsp_tag_out), 64'h07);
    @(negedge clk);
    #1 chk("drain_valid", 64'(bus_r.rsp_valid_out), 64'b000);
    chk("drain_busy", 64'(bus_r.busy), 64'd0);

    // Invalid response index 3
    bus_r.mem_rsp_valid = 1'b1;
    bus_r.mem_rsp_tag   = 10'h0CF;
    #1 chk("inv_mem_rsp_ready", 64'(bus_r.mem_rsp_ready), 64'd1);
    chk("inv_err_before", 64'(bus_r.rsp_err), 64'd0);
    @(negedge clk);
    bus_r.mem_rsp_valid = 1'b0;
    #1 chk("inv_no_valid", 64'(bus_r.rsp_valid_out), 64'b000);
    chk("inv_err_set", 64'(bus_r.rsp_err), 64'd1);
    chk("inv_busy", 64'(bus_r.busy), 64'd0);
    @(negedge clk);
    #1 chk("inv_err_sticky", 64'(bus_r.rsp_err), 64'd1);
    $display("invalid index: rsp_err=%b", bus_r.rsp_err);

    // Reset mid-transfer: register full, one read pending
    bus_r.req_tag_in    = {8'h12, 8'h11, 8'h10};
    bus_r.req_rw_in     = 3'b000;
    bus_r.req_valid_in  = 3'b001;
    bus_r.mem_req_ready = 1'b0;
    #1 chk("mid_ready", 64'(bus_r.req_ready_out), 64'b001);
    @(negedge clk);
    #1 chk("mid_full", 64'(bus_r.mem_req_valid), 64'd1);
    chk("mid_busy", 64'(bus_r.busy), 64'd1);
    chk("mid_stall_ready", 64'(bus_r.req_ready_out), 64'b000);
    reset_n = 1'b0;
    #1 chk("arst_mem_req_valid", 64'(bus_r.mem_req_valid), 64'd0);
    chk("arst_rsp_err", 64'(bus_r.rsp_err), 64'd0);
    chk("arst_busy", 64'(bus_r.busy), 64'd0);
    chk("arst_rsp_valid", 64'(bus_r.rsp_valid_out), 64'b000);
    $display("async reset: mem_req_valid=%b busy=%b rsp_err=%b", bus_r.mem_req_valid, bus_r.busy, bus_r.rsp_err);
    @(negedge clk);
    reset_n = 1'b1;
    bus_r.req_rw_in     = 3'b111;
    bus_r.req_valid_in  = 3'b111;
    bus_r.mem_req_ready = 1'b1;
    #1 chk("post_rst_ready", 64'(bus_r.req_ready_out), 64'b001);
    chk("post_rst_busy", 64'(bus_r.busy), 64'd0);
    @(negedge clk);
    #1 chk("post_rst_ready2", 64'(bus_r.req_ready_out), 64'b010);
    chk("post_rst_tag", 64'(bus_r.mem_req_tag), 64'h040);
    bus_r.req_valid_in = 3'b000;

    // Fixed priority: input 0 wins while valid, input 2 only afterwards
    bus_f.req_valid_in = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("fix%0d_ready", k), 64'(bus_f.req_ready_out), 64'b001);
      if (k > 0) chk($sformatf("fix%0d_tag", k), 64'(bus_f.mem_req_tag), 64'h040);
      $display("fixed %0d: ready=%b tag=%h", k, bus_f.req_ready_out, bus_f.mem_req_tag);
      @(negedge clk);
    end
    bus_f.req_valid_in = 3'b100;
    #1 chk("fix_drop_ready", 64'(bus_f.req_ready_out), 64'b100);
    chk("fix_drop_tag", 64'(bus_f.mem_req_tag), 64'h040);
    @(negedge clk);
    #1 chk("fix_in2_tag", 64'(bus_f.mem_req_tag), 64'h04A);
    chk("fix_in2_addr", 64'(bus_f.mem_req_addr), 64'h202);
    $display("fixed: input 2 granted tag=%h", bus_f.mem_req_tag);
    bus_f.req_valid_in = 3'b000;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
